// File: rtl/fifo_flush_reader.sv
// rtl/fifo_flush_reader.sv - flush-initiating nibble FIFO reader with trailing-pad strip and nibble stream
module fifo_flush_reader #(
    parameter logic [3:0] PAD          = 4'hC,
    parameter int         FLUSH_CYCLES = 1,
    parameter int         TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    output logic        fifo_flush_o,
    input  logic        fifo_flush_done_i,
    input  logic [31:0] fifo_rd_data_i,
    output logic        nib_valid_o,
    input  logic        nib_ready_i,
    output logic [3:0]  nib_data_o,
    output logic        nib_last_o,
    output logic [31:0] word_o,
    output logic [3:0]  nib_count_o,
    output logic        busy_o,
    output logic        xfer_done_o,
    output logic        timeout_o
);

    // One counter serves both the flush hold time and the wait timeout.
    localparam int CNT_MAX = (TIMEOUT > FLUSH_CYCLES) ? TIMEOUT : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [3:0]       idx;
    logic [3:0]       idx_nx;
    logic [31:0]      word_nx;
    logic [3:0]       count_nx;
    logic [3:0]       cap_count;
    logic [31:0]      shifted;
    logic [3:0]       data_nx;
    logic             flush_nx;
    logic             valid_nx;
    logic             last_nx;
    logic             done_nx;
    logic             timeout_nx;
    logic             handshake;
    logic             emit_last;
    logic             wait_expired;

    // Number of nibbles left after dropping the run of PAD nibbles at the top of the word.
    function automatic logic [3:0] valid_count(input logic [31:0] w);
        logic [3:0] n;
        logic       trailing;
        n        = 4'd8;
        trailing = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (trailing && (w[i*4 +: 4] == PAD)) begin
                n = n - 4'd1;
            end else begin
                trailing = 1'b0;
            end
        end
        return n;
    endfunction

    assign cap_count    = valid_count(fifo_rd_data_i);
    assign handshake    = (state == S_EMIT) && nib_valid_o && nib_ready_i;
    assign emit_last    = (idx == (nib_count_o - 4'd1));
    assign wait_expired = (cnt == WAIT_LAST);
    assign busy_o       = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection; a flush-done during FLUSH is deliberately not looked at.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start_i) state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                if (cnt == FLUSH_LAST) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (fifo_flush_done_i) begin
                    state_nx = (cap_count != 4'd0) ? S_EMIT : S_DONE;
                end else if (wait_expired) begin
                    state_nx = S_DONE;
                end
            end
            S_EMIT: begin
                if (handshake && emit_last) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and datapath, derived from the next state.
    always_comb begin
        word_nx  = word_o;
        count_nx = nib_count_o;
        if ((state == S_WAIT) && fifo_flush_done_i) begin
            word_nx  = fifo_rd_data_i;
            count_nx = cap_count;
        end

        idx_nx = idx;
        if (handshake) idx_nx = idx + 4'd1;
        if (state_nx != S_EMIT) idx_nx = 4'd0;

        cnt_nx = '0;
        if ((state_nx == state) && ((state == S_FLUSH) || (state == S_WAIT))) begin
            cnt_nx = cnt + CNT_W'(1);
        end

        timeout_nx = timeout_o;
        if ((state == S_IDLE) && start_i) timeout_nx = 1'b0;
        if ((state == S_WAIT) && !fifo_flush_done_i && wait_expired) timeout_nx = 1'b1;

        flush_nx = (state_nx == S_FLUSH);
        valid_nx = (state_nx == S_EMIT);
        done_nx  = (state_nx == S_DONE);
        last_nx  = valid_nx && (idx_nx == (count_nx - 4'd1));
        shifted  = word_nx >> {idx_nx[2:0], 2'b00};
        data_nx  = valid_nx ? shifted[3:0] : 4'h0;
    end

    // Output and datapath registers; nothing here sees nib_ready_i combinationally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt          <= '0;
            idx          <= 4'd0;
            word_o       <= 32'h0;
            nib_count_o  <= 4'd0;
            fifo_flush_o <= 1'b0;
            nib_valid_o  <= 1'b0;
            nib_data_o   <= 4'h0;
            nib_last_o   <= 1'b0;
            xfer_done_o  <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            cnt          <= cnt_nx;
            idx          <= idx_nx;
            word_o       <= word_nx;
            nib_count_o  <= count_nx;
            fifo_flush_o <= flush_nx;
            nib_valid_o  <= valid_nx;
            nib_data_o   <= data_nx;
            nib_last_o   <= last_nx;
            xfer_done_o  <= done_nx;
            timeout_o    <= timeout_nx;
        end
    end

endmodule
